// File: rtl/serial_rx_32bits.sv
// Serial-to-parallel receiver: 32 data bits LSB first plus one trailing parity bit.
// The assembled word and its parity flag are delivered with a one-cycle valid pulse.
module serial_rx_32bits #(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_start,
  input  logic        in_bit,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_perr,
  output logic        out_abort,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] sreg, sreg_n;
  logic [31:0] data_n;
  logic        valid_n, perr_n, abort_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    data_n  = out_data;
    perr_n  = out_perr;
    valid_n = 1'b0;
    abort_n = 1'b0;
    if (in_valid) begin
      if (in_start) begin
        // A start beat always begins a fresh frame, abandoning any partial one.
        abort_n = (state != IDLE);
        sreg_n  = {in_bit, sreg[31:1]};
        cnt_n   = 5'd1;
        state_n = DATA;
      end else begin
        case (state)
          DATA: begin
            sreg_n = {in_bit, sreg[31:1]};
            cnt_n  = cnt + 5'd1;
            if (cnt == 5'd31) state_n = PARITY;
          end
          PARITY: begin
            data_n  = sreg;
            perr_n  = (^sreg) ^ in_bit ^ ODD_PARITY;
            valid_n = 1'b1;
            state_n = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      sreg      <= 32'h0;
      out_data  <= 32'h0;
      out_perr  <= 1'b0;
      out_valid <= 1'b0;
      out_abort <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sreg      <= sreg_n;
      out_data  <= data_n;
      out_perr  <= perr_n;
      out_valid <= valid_n;
      out_abort <= abort_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_rx_32bits.sv
// Directed bench for serial_rx_32bits: even- and odd-parity instances share stimulus,
// each scored against its own queue of expected words.
module tb_serial_rx_32bits;

  typedef struct packed {
    logic [31:0] data;
    logic        perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_start = 1'b0, in_bit = 1'b0;
  logic [31:0] d0, d1;
  logic        v0, v1, p0, p1, a0, a1, b0, b1;

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, abort0 = 0, abort1 = 0;
  exp_t q0[$], q1[$];
  int   vtimes[$];

  serial_rx_32bits #(.ODD_PARITY(1'b0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start), .in_bit(in_bit),
    .out_data(d0), .out_valid(v0), .out_perr(p0), .out_abort(a0), .busy(b0));

  serial_rx_32bits #(.ODD_PARITY(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start), .in_bit(in_bit),
    .out_data(d1), .out_valid(v1), .out_perr(p1), .out_abort(a1), .busy(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on each valid pulse; a pulse with nothing expected is a failure.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (v0) begin
        vtimes.push_back(cyc);
        if (q0.size() == 0) chk("u0_unexpected_valid", 33'd1, 33'd0);
        else begin
          e = q0.pop_front();
          chk("u0_data", {1'b0, d0}, {1'b0, e.data});
          chk("u0_perr", {32'h0, p0}, {32'h0, e.perr});
        end
      end
      if (v1) begin
        if (q1.size() == 0) chk("u1_unexpected_valid", 33'd1, 33'd0);
        else begin
          e = q1.pop_front();
          chk("u1_data", {1'b0, d1}, {1'b0, e.data});
          chk("u1_perr", {32'h0, p1}, {32'h0, e.perr});
        end
      end
      if (v0 && a0) chk("u0_valid_and_abort", 33'd1, 33'd0);
      if (a0) abort0++;
      if (a1) abort1++;
    end
  end

  task automatic beat(input logic s, input logic b, input int stall_pct);
    while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      in_valid = 1'b0; in_start = $urandom_range(1); in_bit = $urandom_range(1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_start = s; in_bit = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_start = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic par, input int stall_pct);
    int ones;
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      beat(i == 0, w[i], stall_pct);
      if (i == 0) chk("busy_after_start", {32'h0, b0}, 33'd1);
    end
    ones = $countones(w) + par;
    e.data = w;
    e.perr = ones[0];
    q0.push_back(e);
    e.perr = ~ones[0];
    q1.push_back(e);
    beat(1'b0, par, stall_pct);
    chk("valid_after_parity", {32'h0, v0}, 33'd1);
    chk("busy_after_parity", {32'h0, b0}, 33'd0);
  endtask

  initial begin
    int na;
    logic [31:0] hold;
    #2;
    chk("rst_data", {1'b0, d0}, 33'd0);
    chk("rst_flags", {29'h0, v0, p0, a0, b0}, 33'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // good frame, then bad parity; u1 sees the odd-parity view of the same stimulus
    send_frame(32'hA5A5_0F0F, 1'b0, 0);
    @(posedge clk); #1;
    chk("valid_one_cycle", {32'h0, v0}, 33'd0);
    send_frame(32'hA5A5_0F0F, 1'b1, 0);
    @(posedge clk); #1;

    // stalls
    send_frame(32'hFFFF_FFFF, 1'b0, 50);
    @(posedge clk); #1;

    // restart after 10 bits
    hold = d0;
    na = abort0;
    for (int i = 0; i < 10; i++) beat(i == 0, 1'b1, 0);
    chk("hold_before_restart", {1'b0, d0}, {1'b0, hold});
    beat(1'b1, 1'b1, 0);
    chk("abort_pulse", {32'h0, a0}, 33'd1);
    for (int i = 1; i < 32; i++) beat(1'b0, 1'b0, 0);
    chk("hold_before_completion", {1'b0, d0}, {1'b0, hold});
    q0.push_back('{data: 32'h0000_0001, perr: 1'b0});
    q1.push_back('{data: 32'h0000_0001, perr: 1'b1});
    beat(1'b0, 1'b1, 0);
    @(posedge clk); #1;
    chk("abort_count", na + 1, abort0);
    chk("abort_count_u1", na + 1, abort1);

    // junk in IDLE, then back-to-back frames
    for (int i = 0; i < 6; i++) beat(1'b0, $urandom_range(1), 0);
    chk("junk_not_busy", {32'h0, b0}, 33'd0);
    send_frame(32'h1234_5678, ^32'h1234_5678, 0);
    send_frame(32'h8000_0000, 1'b1, 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("b2b_spacing", vtimes[vtimes.size()-1] - vtimes[vtimes.size()-2], 33);

    // asynchronous reset mid-frame with random inputs
    for (int i = 0; i < 6; i++) beat(i == 0, $urandom_range(1), 0);
    #3;
    in_valid = $urandom_range(1); in_start = $urandom_range(1); in_bit = $urandom_range(1);
    reset = 1'b1;
    #1;
    chk("midrst_data", {1'b0, d0}, 33'd0);
    chk("midrst_flags", {29'h0, v0, p0, a0, b0}, 33'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(1); in_start = $urandom_range(1); in_bit = $urandom_range(1);
    end
    in_valid = 1'b0; in_start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_release", {32'h0, b0}, 33'd0);
    send_frame(32'hDEAD_BEEF, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
